// File: rtl/nios_system_irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller slice.
//
// Contents:
//   ADDR_*            word addresses of the Avalon-MM register map
//   irq_state_e       aggregation FSM states
//   IRQ_ID_VALID_BIT  position of the "valid" flag in the IRQ_ID register
package nios_system_irq_pkg;

   localparam logic [2:0] ADDR_PENDING  = 3'd0;
   localparam logic [2:0] ADDR_MASK     = 3'd1;
   localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
   localparam logic [2:0] ADDR_IRQ_ID   = 3'd3;
   localparam logic [2:0] ADDR_HOLDOFF  = 3'd4;
   localparam logic [2:0] ADDR_RAW      = 3'd5;

   localparam int IRQ_ID_VALID_BIT = 15;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      HOLDOFF = 2'd2
   } irq_state_e;

endpackage

// File: rtl/nios_system_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the interrupt controller.
//
// Signals:
//   address    3-bit word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  16-bit write data
//   readdata   16-bit registered read data (driven by the slave)
interface nios_system_irq_ctrl_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );

endinterface

// File: rtl/nios_system_irq_prio_enc.sv
// Lowest-index priority encoder, purely combinational.
//
// Ports:
//   req    NUM_SRC request vector (pending & mask)
//   valid  1 when any request bit is set
//   id     index of the lowest set request bit, 0 when none
module nios_system_irq_prio_enc #(
   parameter int NUM_SRC = 8
) (
   input  logic [NUM_SRC-1:0] req,
   output logic               valid,
   output logic [3:0]         id
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      valid = |req;
      id    = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            id = 4'(i);
         end
      end
   end

endmodule

// File: rtl/nios_system_irq_ctrl.sv
// Interrupt aggregator: collects NUM_SRC peripheral irq lines (timer on bit 0)
// into one registered CPU irq, with per-source mask, level/edge mode,
// write-1-to-clear pending bits, a priority ID register and a holdoff
// (coalescing) period after every irq deassertion.
//
// Ports:
//   clk     system clock
//   reset   synchronous, active-high reset
//   irq_in  NUM_SRC peripheral irq lines, synchronous to clk
//   bus     Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   irq     registered aggregated interrupt to the CPU
//
// Register map: 0 PENDING, 1 MASK, 2 EDGE_SEL, 3 IRQ_ID, 4 HOLDOFF, 5 RAW,
// 6/7 read as zero. Reads have one cycle of latency.
module nios_system_irq_ctrl
   import nios_system_irq_pkg::*;
#(
   parameter int NUM_SRC   = 8,
   parameter int HOLDOFF_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_SRC-1:0]   irq_in,
   nios_system_irq_ctrl_if.slave bus,
   output logic                 irq
);

   logic [NUM_SRC-1:0]   irq_q;
   logic [NUM_SRC-1:0]   pending;
   logic [NUM_SRC-1:0]   pending_nxt;
   logic [NUM_SRC-1:0]   mask;
   logic [NUM_SRC-1:0]   edge_sel;
   logic [HOLDOFF_W-1:0] holdoff;
   logic [HOLDOFF_W-1:0] hold_cnt;
   logic [HOLDOFF_W-1:0] hold_cnt_nxt;
   logic [NUM_SRC-1:0]   rise;
   logic [NUM_SRC-1:0]   w1c;
   logic [15:0]          rd_mux;
   logic                 wr_en;
   logic                 active;
   logic                 id_valid;
   logic [3:0]           id;
   irq_state_e           state;
   irq_state_e           state_nxt;

   assign wr_en  = bus.chipselect && !bus.write_n;
   assign active = |(pending & mask);

   nios_system_irq_prio_enc #(
      .NUM_SRC (NUM_SRC)
   ) u_prio_enc (
      .req   (pending & mask),
      .valid (id_valid),
      .id    (id)
   );

   // Edge-mode bits latch a rising edge and hold it until cleared by a W1C
   // write; a new edge in the same cycle as the clear wins. Level-mode bits
   // simply follow the input one cycle late.
   always_comb begin
      rise        = irq_in & ~irq_q;
      w1c         = '0;
      if (wr_en && (bus.address == ADDR_PENDING)) begin
         w1c = bus.writedata[NUM_SRC-1:0];
      end
      pending_nxt = (edge_sel & (rise | (pending & ~w1c)))
                  | (~edge_sel & irq_in);
   end

   // Read mux; unused upper bits stay zero for narrow configurations.
   always_comb begin
      rd_mux = '0;
      case (bus.address)
         ADDR_PENDING:  rd_mux[NUM_SRC-1:0]   = pending;
         ADDR_MASK:     rd_mux[NUM_SRC-1:0]   = mask;
         ADDR_EDGE_SEL: rd_mux[NUM_SRC-1:0]   = edge_sel;
         ADDR_IRQ_ID: begin
            rd_mux[IRQ_ID_VALID_BIT] = id_valid;
            rd_mux[3:0]              = id;
         end
         ADDR_HOLDOFF:  rd_mux[HOLDOFF_W-1:0] = holdoff;
         ADDR_RAW:      rd_mux[NUM_SRC-1:0]   = irq_q;
         default:       rd_mux                = '0;
      endcase
   end

   // Register file, input sampling and registered read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q        <= '0;
         pending      <= '0;
         mask         <= '0;
         edge_sel     <= '0;
         holdoff      <= '0;
         bus.readdata <= '0;
      end else begin
         irq_q        <= irq_in;
         pending      <= pending_nxt;
         bus.readdata <= rd_mux;
         if (wr_en && (bus.address == ADDR_MASK)) begin
            mask <= bus.writedata[NUM_SRC-1:0];
         end
         if (wr_en && (bus.address == ADDR_EDGE_SEL)) begin
            edge_sel <= bus.writedata[NUM_SRC-1:0];
         end
         if (wr_en && (bus.address == ADDR_HOLDOFF)) begin
            holdoff <= bus.writedata[HOLDOFF_W-1:0];
         end
      end
   end

   // FSM state register; irq is registered from the next state so it is
   // high exactly while the FSM sits in ASSERT.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         hold_cnt <= '0;
         irq      <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
         irq      <= (state_nxt == ASSERT);
      end
   end

   // Next-state logic. Loading holdoff-1 and leaving at zero gives exactly
   // `holdoff` cycles in HOLDOFF; the holdoff value is only sampled on entry,
   // so reprogramming mid-count affects only the next holdoff.
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      case (state)
         IDLE: begin
            if (active) begin
               state_nxt = ASSERT;
            end
         end
         ASSERT: begin
            if (!active) begin
               if (holdoff == '0) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt    = HOLDOFF;
                  hold_cnt_nxt = holdoff - HOLDOFF_W'(1);
               end
            end
         end
         HOLDOFF: begin
            if (hold_cnt == '0) begin
               state_nxt = IDLE;
            end else begin
               hold_cnt_nxt = hold_cnt - HOLDOFF_W'(1);
            end
         end
         default: begin
            state_nxt    = IDLE;
            hold_cnt_nxt = '0;
         end
      endcase
   end

endmodule
